// File: rtl/counter_up_down_param_if.sv
// counter_up_down_param_if: control/status bundle for the parametrised up/down counter
interface counter_up_down_param_if #(parameter int WIDTH = 8);
  logic en_in;
  logic load_in;
  logic [WIDTH-1:0] d_in;
  logic up_down_in;
  logic mode_in;
  logic [WIDTH-1:0] max_in;
  logic clr_flags_in;
  logic [WIDTH-1:0] q_out;
  logic tc_out;
  logic ovf_out;
  logic unf_out;
  modport master (
    output en_in, load_in, d_in, up_down_in, mode_in, max_in, clr_flags_in,
    input q_out, tc_out, ovf_out, unf_out
  );
  modport slave (
    input en_in, load_in, d_in, up_down_in, mode_in, max_in, clr_flags_in,
    output q_out, tc_out, ovf_out, unf_out
  );
endinterface

// File: rtl/counter_up_down_param.sv
// counter_up_down_param: up/down counter with programmable terminal value, wrap/saturate and sticky flags
module counter_up_down_param #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic clk,
  input logic reset_in,
  counter_up_down_param_if.slave bus
);
  logic [WIDTH-1:0] q, q_nxt;
  logic ovf, unf, at_top, at_zero, step, ovf_evt, unf_evt;
  always_comb begin
    at_top = q >= bus.max_in;
    at_zero = q == '0;
    step = bus.en_in & ~bus.load_in;
    ovf_evt = step & bus.up_down_in & at_top;
    unf_evt = step & ~bus.up_down_in & at_zero;
    // counting down from above the bound pulls back to the bound without flagging
    q_nxt = bus.load_in ? (bus.d_in > bus.max_in ? bus.max_in : bus.d_in)
          : !bus.en_in ? q
          : bus.up_down_in ? (at_top ? (bus.mode_in ? bus.max_in : '0) : q + 1'b1)
          : q > bus.max_in ? bus.max_in
          : at_zero ? (bus.mode_in ? '0 : bus.max_in)
          : q - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset_in) begin
      q <= RESET_VALUE;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      q <= q_nxt;
      ovf <= ovf_evt | (ovf & ~bus.clr_flags_in);
      unf <= unf_evt | (unf & ~bus.clr_flags_in);
    end
  end
  assign bus.q_out = q;
  assign bus.tc_out = ovf_evt | unf_evt;
  assign bus.ovf_out = ovf;
  assign bus.unf_out = unf;
endmodule

// File: tb/tb_counter_up_down_param.sv
// tb_counter_up_down_param: scoreboard bench for the single counter and a two-stage cascade
module tb_counter_up_down_param;
  typedef struct {
    logic [3:0] q;
    logic ovf;
    logic unf;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic c_rst;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int csb[$];
  logic [3:0] m_q;
  logic m_ovf, m_unf;
  always #5 clk = ~clk;
  counter_up_down_param_if #(.WIDTH(4)) bus ();
  counter_up_down_param_if #(.WIDTH(4)) lo ();
  counter_up_down_param_if #(.WIDTH(4)) hi ();
  counter_up_down_param #(.WIDTH(4), .RESET_VALUE(4'd0)) dut (.clk(clk), .reset_in(rst), .bus(bus));
  counter_up_down_param #(.WIDTH(4), .RESET_VALUE(4'd0)) u_lo (.clk(clk), .reset_in(c_rst), .bus(lo));
  counter_up_down_param #(.WIDTH(4), .RESET_VALUE(4'd0)) u_hi (.clk(clk), .reset_in(c_rst), .bus(hi));
  assign hi.en_in = lo.tc_out;
  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic ld, input logic [3:0] d, input logic e,
                     input logic u, input logic m, input logic [3:0] mx, input logic c);
    int nq;
    logic ov, un;
    exp_t x;
    @(negedge clk);
    rst = r;
    bus.load_in = ld;
    bus.d_in = d;
    bus.en_in = e;
    bus.up_down_in = u;
    bus.mode_in = m;
    bus.max_in = mx;
    bus.clr_flags_in = c;
    nq = int'(m_q);
    ov = 1'b0;
    un = 1'b0;
    if (ld) nq = (d > mx) ? int'(mx) : int'(d);
    else if (e && u) begin
      if (nq < int'(mx)) nq = nq + 1;
      else begin
        nq = m ? int'(mx) : 0;
        ov = 1'b1;
      end
    end else if (e) begin
      if (nq > int'(mx)) nq = int'(mx);
      else if (nq > 0) nq = nq - 1;
      else begin
        nq = m ? 0 : int'(mx);
        un = 1'b1;
      end
    end
    #1;
    chk("tc", int'(bus.tc_out), int'(ov | un));
    if (r) begin
      m_q = 4'd0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_q = nq[3:0];
      m_ovf = ov ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = un ? 1'b1 : (c ? 1'b0 : m_unf);
    end
    x.q = m_q;
    x.ovf = m_ovf;
    x.unf = m_unf;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("q", int'(bus.q_out), int'(x.q));
    chk("ovf", int'(bus.ovf_out), int'(x.ovf));
    chk("unf", int'(bus.unf_out), int'(x.unf));
  endtask
  initial begin
    int cnt;
    logic h_ovf;
    m_q = 4'd0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    c_rst = 1'b1;
    lo.load_in = 1'b0; lo.d_in = 4'd0; lo.en_in = 1'b0; lo.up_down_in = 1'b1;
    lo.mode_in = 1'b0; lo.max_in = 4'd15; lo.clr_flags_in = 1'b0;
    hi.load_in = 1'b0; hi.d_in = 4'd0; hi.up_down_in = 1'b1;
    hi.mode_in = 1'b0; hi.max_in = 4'd15; hi.clr_flags_in = 1'b0;
    // reset then count 0..9 and wrap
    cyc(1, 1, 4'd3, 1, 1, 0, 4'd9, 0);
    cyc(1, 0, 4'd0, 0, 1, 0, 4'd9, 0);
    chk("reset_q", int'(bus.q_out), 0);
    for (int i = 0; i < 11; i++) cyc(0, 0, 4'd0, 1, 1, 0, 4'd9, 0);
    chk("wrap_q", int'(bus.q_out), 1);
    chk("wrap_ovf", int'(bus.ovf_out), 1);
    // saturate down from 2
    cyc(0, 1, 4'd2, 0, 0, 1, 4'd9, 1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 4'd0, 1, 0, 1, 4'd9, 0);
    chk("sat_q", int'(bus.q_out), 0);
    chk("sat_unf", int'(bus.unf_out), 1);
    cyc(0, 0, 4'd0, 0, 0, 1, 4'd9, 1);
    chk("clr_unf", int'(bus.unf_out), 0);
    // load clamp and load-over-count priority
    cyc(0, 1, 4'd12, 0, 1, 0, 4'd9, 0);
    chk("clamp", int'(bus.q_out), 9);
    cyc(0, 1, 4'd5, 1, 1, 0, 4'd9, 0);
    chk("load_wins", int'(bus.q_out), 5);
    // lowered bound
    cyc(0, 1, 4'd7, 0, 1, 0, 4'd9, 0);
    cyc(0, 0, 4'd0, 1, 1, 0, 4'd4, 0);
    chk("low_up", int'(bus.q_out), 0);
    cyc(0, 0, 4'd0, 0, 1, 0, 4'd9, 1);
    cyc(0, 1, 4'd7, 0, 1, 0, 4'd9, 0);
    cyc(0, 0, 4'd0, 1, 0, 0, 4'd4, 0);
    chk("low_dn", int'(bus.q_out), 4);
    chk("low_dn_unf", int'(bus.unf_out), 0);
    // reset beats load mid-count; set beats clear
    cyc(0, 1, 4'd6, 0, 1, 0, 4'd9, 0);
    cyc(0, 0, 4'd0, 1, 1, 0, 4'd9, 0);
    cyc(1, 1, 4'd3, 1, 1, 0, 4'd9, 0);
    cyc(0, 1, 4'd9, 0, 1, 0, 4'd9, 0);
    cyc(0, 0, 4'd0, 1, 1, 0, 4'd9, 1);
    chk("set_wins", int'(bus.ovf_out), 1);
    // zero bound
    cyc(0, 0, 4'd0, 0, 1, 0, 4'd0, 1);
    for (int m = 0; m < 2; m++) begin
      cyc(0, 1, 4'd5, 0, 1, m[0], 4'd0, 0);
      cyc(0, 0, 4'd0, 1, 1, m[0], 4'd0, 0);
      cyc(0, 0, 4'd0, 1, 0, m[0], 4'd0, 0);
      chk("zero_q", int'(bus.q_out), 0);
    end
    // random mix, bound skewed to exercise edges
    for (int i = 0; i < 300; i++)
      cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 7) == 0), 4'($urandom),
          ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(3, 15)),
          ($urandom_range(0, 9) == 0));
    // cascade: 8-bit count via lo.tc_out -> hi.en_in
    @(negedge clk);
    c_rst = 1'b0;
    lo.en_in = 1'b1;
    cnt = 0;
    h_ovf = 1'b0;
    for (int i = 0; i < 260; i++) begin
      h_ovf = h_ovf | (cnt == 255);
      cnt = (cnt + 1) & 255;
      csb.push_back({h_ovf, cnt[7:0]});
      @(posedge clk);
      #1;
      begin
        int e;
        e = csb.pop_front();
        chk("casc_q", int'({hi.q_out, lo.q_out}), e & 255);
        chk("casc_ovf", int'(hi.ovf_out), e >> 8);
      end
      @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
